riscv_hazard_ctrl: RTL and testbench
====================================

# riscv_hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core. It watches the ID, EX and MEM stages and drives the stall, flush and bubble controls for the PC, IF/ID and ID/EX registers, and the freeze control for EX/MEM. It covers three cases: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses. A watchdog halts the core if a memory access never completes.

## Interface
- REGFILE_COUNT, 32, number of architectural registers; register index width is $clog2(REGFILE_COUNT)
- MEM_TIMEOUT, 255, maximum consecutive memory-wait cycles before halting; must be ≥1
- Reset is asynchronous, active-high: rst_i.
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous active-high reset
- id_valid_i  in  1  ID holds a real instruction
- id_rs0_i, id_rs1_i  in  $clog2(REGFILE_COUNT)  ID source register indices
- id_uses_rs0_i, id_uses_rs1_i  in  1  instruction actually reads that source
- ex_valid_i  in  1  EX holds a real instruction
- ex_rd_i  in  $clog2(REGFILE_COUNT)  EX destination register
- ex_mem_read_i  in  1  EX instruction is a load
- branch_taken_i  in  1  EX resolved a taken branch or jump this cycle
- mem_req_i  in  1  MEM stage issues a data-memory read or write this cycle
- mem_ready_i  in  1  data memory completes the access this cycle
- pc_stall_o  out  1  hold PC
- if_id_stall_o  out  1  hold IF/ID register
- if_id_flush_o  out  1  load NOP into IF/ID
- id_ex_bubble_o  out  1  load NOP (all control bits zero) into ID/EX
- ex_mem_stall_o  out  1  hold EX/MEM register and MEM/WB register
- halt_o  out  1  watchdog tripped; core frozen
- stall_cnt_o, flush_cnt_o  out  32  perf counters (only with RISCV_HAZARD_PERF_EN)

## Operation
- FSM states:
  - RUN: normal operation.
  - MEM_WAIT: waiting on a multi-cycle data-memory access.
  - HALT: terminal until reset.
- The state register is registered. All control outputs are Mealy outputs, decoded from the state and the current inputs.
- Load-use condition: ex_valid_i & ex_mem_read_i & ex_rd_i≠0 & id_valid_i & ((id_uses_rs0_i & id_rs0_i==ex_rd_i) | (id_uses_rs1_i & id_rs1_i==ex_rd_i)).
- Memory-busy condition: mem_req_i & !mem_ready_i.
- Priority within RUN, highest first:
  1. Memory-busy: assert pc_stall_o, if_id_stall_o, ex_mem_stall_o; hold ID/EX with id_ex_bubble_o=0. branch_taken_i and load-use are ignored this cycle. Next state is MEM_WAIT.
  2. branch_taken_i: assert if_id_flush_o and id_ex_bubble_o. PC is not stalled, so it takes the branch target. Load-use is ignored.
  3. Load-use: assert pc_stall_o, if_id_stall_o and id_ex_bubble_o.
  4. Otherwise all outputs are 0.
- MEM_WAIT: outputs are the same as memory-busy in RUN.
  - If mem_ready_i: release all stalls this cycle, return to RUN and clear the wait counter. Branch and load-use are evaluated this cycle with RUN priority 2–4.
  - Else the wait counter increments. When the count reaches MEM_TIMEOUT, next state is HALT.
  - mem_ready_i in the same cycle the count reaches MEM_TIMEOUT: ready wins and the FSM goes to RUN.
- HALT: pc_stall_o, if_id_stall_o, ex_mem_stall_o, id_ex_bubble_o and halt_o are all 1. All inputs are ignored.
- Wait counter width is $clog2(MEM_TIMEOUT+1). It counts the consecutive MEM_WAIT cycles without ready, starting from 1 on the RUN→MEM_WAIT transition, and never wraps.

## Timing
- While rst_i=1:
  - id_ex_bubble_o=1; all other control outputs 0; halt_o=0.
  - State resets to RUN, wait counter to 0, perf counters to 0.
- The first clock edge after rst_i falls evaluates normally.
- Load-use costs exactly one bubble; the dependent instruction proceeds in the next cycle with MEM forwarding.
- Taken branch costs two squashed instructions in the same cycle.
- Memory access with N wait cycles (mem_ready_i first high on cycle N+1) freezes the pipeline for exactly N cycles.
- Reset asserted mid-MEM_WAIT or in HALT returns to RUN immediately (asynchronously).

## Configuration
- RISCV_HAZARD_PERF_EN defined:
  - stall_cnt_o increments on every cycle with pc_stall_o=1 and rst_i=0.
  - flush_cnt_o increments on every cycle with if_id_flush_o=1.
  - Both counters saturate at 32'hFFFF_FFFF.
- RISCV_HAZARD_PERF_EN undefined: both ports and all counter logic are absent.

## Structure
- riscv_pkg holds:
  - the hazard_state_e enum (RUN, MEM_WAIT, HALT);
  - REG_IDX_W derived from REGFILE_COUNT;
  - a localparam for the perf counter width (32).
- Sub-module riscv_sat_counter: parameterised-width saturating counter with increment enable and async active-high clear. It is instantiated twice under RISCV_HAZARD_PERF_EN.

## Test plan
- Load-use: EX load with rd=5, ID reads rs0=5 with id_uses_rs0_i=1 → one cycle with pc_stall_o=1, if_id_stall_o=1, id_ex_bubble_o=1. Same setup with rd=0 → no stall.
- Taken branch and load-use together → only if_id_flush_o=1 and id_ex_bubble_o=1; pc_stall_o=0.
- mem_req_i=1 with mem_ready_i low for 3 cycles, then high → ex_mem_stall_o=1 for exactly 3 cycles; a branch_taken_i held during the wait flushes only in the release cycle.
- MEM_TIMEOUT=4 with mem_ready_i never high → halt_o=1 from the cycle after the 4th wait cycle and stays 1. mem_ready_i arriving exactly on the 4th wait cycle → RUN, halt_o=0.
- rst_i pulsed during MEM_WAIT → all stalls 0 and id_ex_bubble_o=1 while reset is high; RUN afterwards.
- With RISCV_HAZARD_PERF_EN: 3 wait cycles plus one load-use → stall_cnt_o=4. Counter preloaded near saturation stays at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V pipeline control blocks.
package riscv_pkg;

  localparam int unsigned REGFILE_COUNT_DFLT = 32;
  localparam int unsigned REG_IDX_W          = $clog2(REGFILE_COUNT_DFLT);
  localparam int unsigned PERF_CNT_W         = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hazard_state_e;

endpackage

// File: rtl/riscv_sat_counter.sv
// Saturating up-counter with increment enable and asynchronous active-high clear.
module riscv_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, memory-wait freeze and watchdog halt.
// Optional perf counters are built when RISCV_HAZARD_PERF_EN is defined.
module riscv_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned REGFILE_COUNT = REGFILE_COUNT_DFLT,
  parameter int unsigned MEM_TIMEOUT   = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             id_valid_i,
  input  logic [$clog2(REGFILE_COUNT)-1:0] id_rs0_i,
  input  logic [$clog2(REGFILE_COUNT)-1:0] id_rs1_i,
  input  logic                             id_uses_rs0_i,
  input  logic                             id_uses_rs1_i,
  input  logic                             ex_valid_i,
  input  logic [$clog2(REGFILE_COUNT)-1:0] ex_rd_i,
  input  logic                             ex_mem_read_i,
  input  logic                             branch_taken_i,
  input  logic                             mem_req_i,
  input  logic                             mem_ready_i,
  output logic                             pc_stall_o,
  output logic                             if_id_stall_o,
  output logic                             if_id_flush_o,
  output logic                             id_ex_bubble_o,
  output logic                             ex_mem_stall_o,
  output logic                             halt_o
`ifdef RISCV_HAZARD_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0]            stall_cnt_o,
  output logic [PERF_CNT_W-1:0]            flush_cnt_o
`endif
);

  localparam int unsigned       WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hazard_state_e     state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic              load_use, mem_busy;
  logic              run_stall, run_flush, run_bubble;

  assign load_use = ex_valid_i & ex_mem_read_i & (ex_rd_i != '0) & id_valid_i &
                    ((id_uses_rs0_i & (id_rs0_i == ex_rd_i)) |
                     (id_uses_rs1_i & (id_rs1_i == ex_rd_i)));
  assign mem_busy = mem_req_i & ~mem_ready_i;
  assign wait_inc = wait_q + WAIT_W'(1);

  // Branch outranks load-use: the dependent instruction is squashed anyway.
  assign run_flush  = branch_taken_i;
  assign run_bubble = branch_taken_i | load_use;
  assign run_stall  = ~branch_taken_i & load_use;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    ex_mem_stall_o = 1'b0;
    halt_o         = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_busy) begin
          pc_stall_o     = 1'b1;
          if_id_stall_o  = 1'b1;
          ex_mem_stall_o = 1'b1;
          wait_d         = WAIT_W'(1);
          state_d        = (WAIT_MAX <= WAIT_W'(1)) ? HALT : MEM_WAIT;
        end else begin
          pc_stall_o     = run_stall;
          if_id_stall_o  = run_stall;
          if_id_flush_o  = run_flush;
          id_ex_bubble_o = run_bubble;
        end
      end
      MEM_WAIT: begin
        if (mem_ready_i) begin
          pc_stall_o     = run_stall;
          if_id_stall_o  = run_stall;
          if_id_flush_o  = run_flush;
          id_ex_bubble_o = run_bubble;
          wait_d         = '0;
          state_d        = RUN;
        end else begin
          pc_stall_o     = 1'b1;
          if_id_stall_o  = 1'b1;
          ex_mem_stall_o = 1'b1;
          wait_d         = wait_inc;
          if (wait_inc >= WAIT_MAX) begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
        ex_mem_stall_o = 1'b1;
        halt_o         = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Reset forces a bubble into ID/EX and drops every other control.
    if (rst_i) begin
      pc_stall_o     = 1'b0;
      if_id_stall_o  = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
      ex_mem_stall_o = 1'b0;
      halt_o         = 1'b0;
    end
  end

`ifdef RISCV_HAZARD_PERF_EN
  riscv_sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .clr   (rst_i),
    .inc   (pc_stall_o & ~rst_i),
    .count (stall_cnt_o)
  );

  riscv_sat_counter #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .clr   (rst_i),
    .inc   (if_id_flush_o),
    .count (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Self-checking bench for riscv_hazard_ctrl (MEM_TIMEOUT=4) and riscv_sat_counter.
// Perf counter checks are included when RISCV_HAZARD_PERF_EN is defined.
module tb_riscv_hazard_ctrl;
  import riscv_pkg::*;

  localparam int unsigned TMO   = 4;
  localparam int unsigned SAT_W = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 id_valid_i;
  logic [REG_IDX_W-1:0] id_rs0_i, id_rs1_i;
  logic                 id_uses_rs0_i, id_uses_rs1_i;
  logic                 ex_valid_i;
  logic [REG_IDX_W-1:0] ex_rd_i;
  logic                 ex_mem_read_i;
  logic                 branch_taken_i;
  logic                 mem_req_i;
  logic                 mem_ready_i;
  logic                 pc_stall_o, if_id_stall_o, if_id_flush_o;
  logic                 id_ex_bubble_o, ex_mem_stall_o, halt_o;
`ifdef RISCV_HAZARD_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt_o, flush_cnt_o;
`endif

  logic             sat_clr, sat_inc;
  logic [SAT_W-1:0] sat_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        m_halt, m_wait;
  int unsigned m_cnt;
  logic [31:0] m_stall, m_flush;
  logic [5:0]  last_o;
  int unsigned n_frz;
  int unsigned exp_sat;

  always #5 clk_i = ~clk_i;

  riscv_hazard_ctrl #(.REGFILE_COUNT(REGFILE_COUNT_DFLT), .MEM_TIMEOUT(TMO)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_rs0_i       (id_rs0_i),
    .id_rs1_i       (id_rs1_i),
    .id_uses_rs0_i  (id_uses_rs0_i),
    .id_uses_rs1_i  (id_uses_rs1_i),
    .ex_valid_i     (ex_valid_i),
    .ex_rd_i        (ex_rd_i),
    .ex_mem_read_i  (ex_mem_read_i),
    .branch_taken_i (branch_taken_i),
    .mem_req_i      (mem_req_i),
    .mem_ready_i    (mem_ready_i),
    .pc_stall_o     (pc_stall_o),
    .if_id_stall_o  (if_id_stall_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_bubble_o (id_ex_bubble_o),
    .ex_mem_stall_o (ex_mem_stall_o),
    .halt_o         (halt_o)
`ifdef RISCV_HAZARD_PERF_EN
    ,
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  riscv_sat_counter #(.WIDTH(SAT_W)) u_sat (
    .clk   (clk_i),
    .clr   (sat_clr),
    .inc   (sat_inc),
    .count (sat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected controls {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, halt}.
  function automatic logic [5:0] model_out();
    logic       lu;
    logic [5:0] run_v;
    lu = ex_valid_i && ex_mem_read_i && (ex_rd_i != 0) && id_valid_i &&
         ((id_uses_rs0_i && id_rs0_i == ex_rd_i) || (id_uses_rs1_i && id_rs1_i == ex_rd_i));
    run_v = branch_taken_i ? 6'b001100 : (lu ? 6'b110100 : 6'b000000);
    if (rst_i)                     return 6'b000100;
    if (m_halt)                    return 6'b110111;
    if (m_wait)                    return mem_ready_i ? run_v : 6'b110010;
    if (mem_req_i && !mem_ready_i) return 6'b110010;
    return run_v;
  endfunction

  task automatic model_step(input logic [5:0] e);
    if (rst_i) begin
      m_halt = 1'b0; m_wait = 1'b0; m_cnt = 0; m_stall = '0; m_flush = '0;
      return;
    end
    if (e[5] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (e[3] && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
    if (m_halt) begin
      // stays halted until reset
    end else if (m_wait) begin
      if (mem_ready_i) begin
        m_wait = 1'b0; m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
        if (m_cnt >= TMO) begin m_halt = 1'b1; m_wait = 1'b0; end
      end
    end else if (mem_req_i && !mem_ready_i) begin
      m_cnt = 1;
      if (m_cnt >= TMO) m_halt = 1'b1;
      else m_wait = 1'b1;
    end
  endtask

  task automatic tick();
    logic [5:0] e;
    #2;
    e = model_out();
    last_o = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, ex_mem_stall_o, halt_o};
    chk("pc_stall",     32'(last_o[5]), 32'(e[5]));
    chk("if_id_stall",  32'(last_o[4]), 32'(e[4]));
    chk("if_id_flush",  32'(last_o[3]), 32'(e[3]));
    chk("id_ex_bubble", 32'(last_o[2]), 32'(e[2]));
    chk("ex_mem_stall", 32'(last_o[1]), 32'(e[1]));
    chk("halt",         32'(last_o[0]), 32'(e[0]));
`ifdef RISCV_HAZARD_PERF_EN
    chk("stall_cnt", stall_cnt_o, m_stall);
    chk("flush_cnt", flush_cnt_o, m_flush);
`endif
    @(posedge clk_i);
    model_step(e);
    @(negedge clk_i);
  endtask

  task automatic clear_in();
    id_valid_i = 1'b0; id_rs0_i = '0; id_rs1_i = '0;
    id_uses_rs0_i = 1'b0; id_uses_rs1_i = 1'b0;
    ex_valid_i = 1'b0; ex_rd_i = '0; ex_mem_read_i = 1'b0;
    branch_taken_i = 1'b0; mem_req_i = 1'b0; mem_ready_i = 1'b0;
  endtask

  task automatic set_load_use(input logic [REG_IDX_W-1:0] rd);
    ex_valid_i = 1'b1; ex_mem_read_i = 1'b1; ex_rd_i = rd;
    id_valid_i = 1'b1; id_rs0_i = rd; id_uses_rs0_i = 1'b1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    m_halt = 1'b0; m_wait = 1'b0; m_cnt = 0; m_stall = '0; m_flush = '0;
    sat_clr = 1'b1; sat_inc = 1'b0;
    clear_in();

    // Reset state
    rst_i = 1'b1;
    tick();
    chk("rst_bubble", 32'(last_o[2]), 32'd1);
    tick();
    rst_i = 1'b0;

    // Load-use with rd=5, then the dependent instruction proceeds
    set_load_use(5'd5);
    tick();
    chk("lu_stall_vec", 32'(last_o), 32'b110100);
    clear_in();
    id_valid_i = 1'b1; id_rs0_i = 5'd5; id_uses_rs0_i = 1'b1;
    tick();
    chk("lu_after_vec", 32'(last_o), 32'b000000);

    // Same setup with rd=0 never stalls
    set_load_use(5'd0);
    tick();
    chk("lu_rd0_vec", 32'(last_o), 32'b000000);

    // Branch together with load-use
    set_load_use(5'd7);
    branch_taken_i = 1'b1;
    tick();
    chk("br_lu_vec", 32'(last_o), 32'b001100);
    clear_in();

    // Three wait cycles with a branch held throughout
    n_frz = 0;
    mem_req_i = 1'b1; branch_taken_i = 1'b1; mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_frz += 32'(last_o[1]);
      chk("wait_no_flush", 32'(last_o[3]), 32'd0);
    end
    mem_ready_i = 1'b1;
    tick();
    n_frz += 32'(last_o[1]);
    chk("release_flush", 32'(last_o[3]), 32'd1);
    chk("freeze_cycles", n_frz, 32'd3);
    clear_in();
    tick();

    // Watchdog: ready never arrives
    mem_req_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    clear_in();
    tick();
    chk("halt_after_4", 32'(last_o[0]), 32'd1);
    branch_taken_i = 1'b1; mem_ready_i = 1'b1;
    tick();
    chk("halt_sticky", 32'(last_o[0]), 32'd1);
    clear_in();
    do_reset();

    // Ready exactly on the 4th wait cycle
    mem_req_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    mem_ready_i = 1'b1;
    tick();
    clear_in();
    tick();
    chk("ready_at_limit_halt", 32'(last_o[0]), 32'd0);

    // Reset pulsed mid-wait
    mem_req_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    chk("rst_wait_vec", 32'(last_o), 32'b000100);
    rst_i = 1'b0;
    clear_in();
    tick();
    chk("run_after_rst", 32'(last_o), 32'b000000);

    // Three wait cycles plus one load-use
    do_reset();
    mem_req_i = 1'b1;
    tick();
    tick();
    tick();
    mem_ready_i = 1'b1;
    tick();
    clear_in();
    set_load_use(5'd9);
    tick();
    clear_in();
    tick();
`ifdef RISCV_HAZARD_PERF_EN
    chk("stall_cnt_4", stall_cnt_o, 32'd4);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      id_valid_i     = 1'($urandom_range(1, 0));
      id_rs0_i       = REG_IDX_W'($urandom_range(3, 0));
      id_rs1_i       = REG_IDX_W'($urandom_range(3, 0));
      id_uses_rs0_i  = 1'($urandom_range(1, 0));
      id_uses_rs1_i  = 1'($urandom_range(1, 0));
      ex_valid_i     = 1'($urandom_range(1, 0));
      ex_rd_i        = REG_IDX_W'($urandom_range(3, 0));
      ex_mem_read_i  = 1'($urandom_range(1, 0));
      branch_taken_i = ($urandom_range(7, 0) == 0);
      mem_req_i      = ($urandom_range(4, 0) == 0);
      mem_ready_i    = 1'($urandom_range(1, 0));
      rst_i          = (m_halt && $urandom_range(7, 0) == 0) || ($urandom_range(199, 0) == 0);
      tick();
    end
    rst_i = 1'b0;
    clear_in();

    // Saturating counter on its own at a narrow width
    sat_clr = 1'b1; sat_inc = 1'b1;
    #2;
    chk("sat_clr", 32'(sat_cnt), 32'd0);
    @(negedge clk_i);
    sat_clr = 1'b0;
    exp_sat = 0;
    for (int i = 0; i < 24; i++) begin
      sat_inc = (i % 5 != 3);
      #2;
      chk("sat_cnt", 32'(sat_cnt), exp_sat);
      @(posedge clk_i);
      if (sat_inc && exp_sat < (1 << SAT_W) - 1) exp_sat++;
      @(negedge clk_i);
    end
    chk("sat_top", 32'(sat_cnt), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
